line_raster: RTL and testbench
==============================

LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 SHALL have parameter COORD_W, default 16, giving the unsigned coordinate width.
REQ-002 SHALL have parameter ERR_W, default COORD_W+2, giving the signed error-term width.
REQ-003 clk  input  1  system clock; the only clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clk_enb  input  1  clock enable; when low, no state, register or handshake change occurs.
REQ-006 start  input  1  request to rasterise a line; sampled only in IDLE.
REQ-007 start_x, start_y, end_x, end_y  input  COORD_W each  line endpoints, unsigned, captured on start acceptance.
REQ-008 out_valid  output  1  current point is presented.
REQ-009 out_ready  input  1  downstream accepts the point; transfer = out_valid & out_ready & clk_enb.
REQ-010 out_x, out_y  output  COORD_W each  current point.
REQ-011 out_last  output  1  current point equals (end_x,end_y).
REQ-012 busy  output  1  high in SETUP and RUN.
REQ-013 done  output  1  one-cycle pulse after the last point transfers.

Function
REQ-014 States SHALL be IDLE, SETUP and RUN.
REQ-015 IDLE->SETUP on start & clk_enb; endpoints are latched; start while busy is ignored.
REQ-016 SETUP SHALL compute dx=|end_x-start_x|, dy=-|end_y-start_y|, step_x/step_y = +1 or -1 (+1 when equal), err=dx+dy, and load out_x/out_y with the start point; then go to RUN.
REQ-017 out_valid SHALL be high only in RUN; the first point is valid on the second enabled edge after start.
REQ-018 On each transfer, with e2=2*err: if e2>=dy then err+=dy, x+=step_x; if e2<=dx then err+=dx, y+=step_y. Both updates use the same e2.
REQ-019 The block SHALL emit exactly max(dx,|dy|)+1 points, one per transfer at most; throughput is 1 point/cycle with out_ready held high.
REQ-020 out_x, out_y and out_last SHALL hold stable while out_valid & ~out_ready.
REQ-021 On a transfer with out_last high: go to IDLE, pulse done for one enabled cycle, and drop out_valid in the same edge.
REQ-022 Degenerate line (start==end) SHALL produce a single point with out_last high.
REQ-023 Error arithmetic SHALL be ERR_W-bit signed, without overflow for any endpoints, including a full-range 0 to 2^COORD_W-1 span.
REQ-024 Coordinate stepping SHALL never wrap; the line ends exactly at the endpoint.
REQ-025 If clk_enb is low, out_valid/out_x/out_y/done SHALL hold; a done pulse lasts until the next enabled edge.

Reset
REQ-026 rst SHALL force IDLE with out_valid=0, out_last=0, busy=0, done=0, out_x=0, out_y=0 and err=0, regardless of clk_enb.
REQ-027 rst mid-line SHALL abort the line with no further points and no done pulse; a start in the first post-reset cycle is accepted.

Structure
REQ-028 Package raster_pkg SHALL hold the state enum (IDLE/SETUP/RUN) and the default COORD_W constant.
REQ-029 Sub-module line_step SHALL hold the combinational Bresenham update (err,x,y -> next err,x,y); line_raster SHALL hold the FSM, handshake and registers.

Verification
REQ-030 (0,5)->(4,5), out_ready=1: points x=0..4, y=5; out_last on the 5th point; done pulse on the next cycle.
REQ-031 (10,0)->(7,0): points 10,9,8,7 with y=0; (2,0)->(2,3): y=0..3 with x=2.
REQ-032 (0,0)->(4,2): points (0,0),(1,1),(2,1),(3,2),(4,2) in order; exactly 5 transfers.
REQ-033 (0,0)->(4,2) with out_ready low for 3 cycles after the 2nd point: out_x/out_y hold at (1,1); no point is dropped or duplicated.
REQ-034 (3,3)->(3,3): one point (3,3) with out_last=1, then done; also (0,0)->(65535,1) yields 65536 points ending at (65535,1).
REQ-035 rst during the 3rd point of (0,0)->(9,9) gives out_valid=0 and busy=0 on the next cycle; clk_enb low for 4 cycles mid-line freezes all outputs.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and defaults for the Bresenham line rasteriser.
// Holds the control-state encoding and the default coordinate width.
package raster_pkg;

    localparam int DEF_COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN
    } state_t;

endpackage

// File: rtl/line_step.sv
// One combinational Bresenham step: (err, x, y) -> next (err, x, y).
// Works one bit wider than err so that 2*err cannot overflow.
module line_step
    import raster_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int ERR_W   = COORD_W + 2
) (
    input  logic signed [ERR_W-1:0]   err,
    input  logic signed [ERR_W-1:0]   dx,
    input  logic signed [ERR_W-1:0]   dy,
    input  logic        [COORD_W-1:0] x,
    input  logic        [COORD_W-1:0] y,
    input  logic                      neg_x,
    input  logic                      neg_y,
    output logic signed [ERR_W-1:0]   err_next,
    output logic        [COORD_W-1:0] x_next,
    output logic        [COORD_W-1:0] y_next
);

    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] err_w;
    logic signed [ERR_W:0] dx_w;
    logic signed [ERR_W:0] dy_w;
    logic signed [ERR_W:0] acc;
    logic                  move_x;
    logic                  move_y;

    always_comb begin
        e2     = {err, 1'b0};
        err_w  = {err[ERR_W-1], err};
        dx_w   = {dx[ERR_W-1], dx};
        dy_w   = {dy[ERR_W-1], dy};
        move_x = e2 >= dy_w;
        move_y = e2 <= dx_w;
        acc    = err_w;
        if (move_x) acc = acc + dy_w;
        if (move_y) acc = acc + dx_w;
        err_next = acc[ERR_W-1:0];
        x_next   = x;
        y_next   = y;
        if (move_x) x_next = neg_x ? x - COORD_W'(1) : x + COORD_W'(1);
        if (move_y) y_next = neg_y ? y - COORD_W'(1) : y + COORD_W'(1);
    end

endmodule

// File: rtl/line_raster.sv
// Streaming Bresenham line rasteriser with valid/ready output.
// IDLE latches endpoints, SETUP derives deltas, RUN emits one point per transfer.
module line_raster
    import raster_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int ERR_W   = COORD_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enb,
    input  logic               start,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic [COORD_W-1:0] end_x,
    input  logic [COORD_W-1:0] end_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    state_t state;
    state_t state_next;

    logic        [COORD_W-1:0] sx, sy, ex, ey;
    logic        [COORD_W-1:0] ax, ay;
    logic        [COORD_W-1:0] x_step, y_step;
    logic signed [ERR_W-1:0]   dx, dy, err, err_step;
    logic signed [ERR_W-1:0]   dx_set, dy_set;
    logic                      neg_x, neg_y;
    logic                      xfer;

    assign out_valid = state == RUN;
    assign busy      = state != IDLE;
    assign out_last  = out_valid & (out_x == ex) & (out_y == ey);
    assign xfer      = out_valid & out_ready & clk_enb;

    assign ax     = (ex >= sx) ? ex - sx : sx - ex;
    assign ay     = (ey >= sy) ? ey - sy : sy - ey;
    assign dx_set = {{(ERR_W-COORD_W){1'b0}}, ax};
    assign dy_set = -{{(ERR_W-COORD_W){1'b0}}, ay};

    line_step #(
        .COORD_W (COORD_W),
        .ERR_W   (ERR_W)
    ) u_step (
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .x        (out_x),
        .y        (out_y),
        .neg_x    (neg_x),
        .neg_y    (neg_y),
        .err_next (err_step),
        .x_next   (x_step),
        .y_next   (y_step)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = RUN;
            RUN:     if (out_ready && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)          state <= IDLE;
        else if (clk_enb) state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sx    <= '0;
            sy    <= '0;
            ex    <= '0;
            ey    <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            neg_x <= 1'b0;
            neg_y <= 1'b0;
            out_x <= '0;
            out_y <= '0;
            done  <= 1'b0;
        end else if (clk_enb) begin
            done <= xfer & out_last;
            unique case (state)
                IDLE: if (start) begin
                    sx <= start_x;
                    sy <= start_y;
                    ex <= end_x;
                    ey <= end_y;
                end
                SETUP: begin
                    dx    <= dx_set;
                    dy    <= dy_set;
                    err   <= dx_set + dy_set;
                    neg_x <= ex < sx;
                    neg_y <= ey < sy;
                    out_x <= sx;
                    out_y <= sy;
                end
                // the final point is never stepped past, so coordinates cannot wrap
                RUN: if (xfer && !out_last) begin
                    err   <= err_step;
                    out_x <= x_step;
                    out_y <= y_step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Directed, table-driven bench for line_raster.
// Expected point lists are hand-computed Bresenham sequences.
module tb_line_raster;

    localparam int CW = 16;
    localparam logic [31:0] Z = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_enb;
    logic          start;
    logic [CW-1:0] start_x, start_y, end_x, end_y;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_x, out_y;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CW-1:0]        sx, sy, ex, ey;
        int                   n;
        logic [0:7][31:0]     pts;
    } vec_t;

    vec_t vecs[7];

    line_raster #(.COORD_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_enb   (clk_enb),
        .start     (start),
        .start_x   (start_x),
        .start_y   (start_y),
        .end_x     (end_x),
        .end_y     (end_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] p(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    function automatic vec_t mk(input int sx, input int sy, input int ex,
                                input int ey, input int n,
                                input logic [0:7][31:0] pts);
        vec_t v;
        v.sx  = sx[CW-1:0];
        v.sy  = sy[CW-1:0];
        v.ex  = ex[CW-1:0];
        v.ey  = ey[CW-1:0];
        v.n   = n;
        v.pts = pts;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // stall_kind: 0 none, 1 out_ready low, 2 clk_enb low
    task automatic run_line(input vec_t v, input int stall_kind,
                            input int stall_at, input int stall_len);
        logic [31:0] e;
        logic        last;
        start_x = v.sx;
        start_y = v.sy;
        end_x   = v.ex;
        end_y   = v.ey;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("setup_state", 64'({out_valid, busy}), 64'(2'b01));
        @(negedge clk);
        check("first_valid", 64'({out_valid, busy}), 64'(2'b11));
        for (int got = 0; got < v.n; got++) begin
            e    = v.pts[got];
            last = (got == v.n - 1);
            if (stall_kind != 0 && got == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    if (stall_kind == 1) begin
                        out_ready = 1'b0;
                        start     = 1'b1;
                        end_x     = 16'd9;
                        end_y     = 16'd9;
                    end else begin
                        clk_enb = 1'b0;
                    end
                    @(negedge clk);
                    check("hold", 64'({out_valid, out_x, out_y, out_last, done}),
                          64'({1'b1, e, last, 1'b0}));
                end
                out_ready = 1'b1;
                clk_enb   = 1'b1;
                start     = 1'b0;
            end
            check("point", 64'({out_valid, out_x, out_y, out_last}),
                  64'({1'b1, e, last}));
            @(negedge clk);
        end
        check("done_pulse", 64'({out_valid, busy, done}), 64'(3'b001));
        @(negedge clk);
        check("done_clear", 64'({out_valid, busy, done}), 64'(3'b000));
    endtask

    initial begin
        int cnt;
        int bad;
        int cyc;

        vecs[0] = mk(0, 5, 4, 5, 5,
            {p(0,5), p(1,5), p(2,5), p(3,5), p(4,5), Z, Z, Z});
        vecs[1] = mk(10, 0, 7, 0, 4,
            {p(10,0), p(9,0), p(8,0), p(7,0), Z, Z, Z, Z});
        vecs[2] = mk(2, 0, 2, 3, 4,
            {p(2,0), p(2,1), p(2,2), p(2,3), Z, Z, Z, Z});
        vecs[3] = mk(0, 0, 4, 2, 5,
            {p(0,0), p(1,1), p(2,1), p(3,2), p(4,2), Z, Z, Z});
        vecs[4] = mk(3, 3, 3, 3, 1,
            {p(3,3), Z, Z, Z, Z, Z, Z, Z});
        vecs[5] = mk(5, 2, 1, 4, 5,
            {p(5,2), p(4,3), p(3,3), p(2,4), p(1,4), Z, Z, Z});
        vecs[6] = mk(1, 7, 3, 1, 7,
            {p(1,7), p(1,6), p(2,5), p(2,4), p(2,3), p(3,2), p(3,1), Z});

        // reset while clk_enb is low must still clear everything
        rst       = 1'b1;
        clk_enb   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        start_x   = '0;
        start_y   = '0;
        end_x     = '0;
        end_y     = '0;
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({out_valid, busy, done, out_last, out_x, out_y}), 64'(0));
        rst     = 1'b0;
        clk_enb = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_line(vecs[i], 0, 0, 0);

        run_line(vecs[3], 1, 1, 3);
        run_line(vecs[6], 2, 3, 4);

        // abort (0,0)->(9,9) while its third point is presented
        start_x = 16'd0;
        start_y = 16'd0;
        end_x   = 16'd9;
        end_y   = 16'd9;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pt3", 64'({out_valid, out_x, out_y}),
              64'({1'b1, 16'd2, 16'd2}));
        rst = 1'b1;
        @(negedge clk);
        check("abort_state",
              64'({out_valid, busy, done, out_last, out_x, out_y}), 64'(0));
        rst = 1'b0;
        run_line(vecs[5], 0, 0, 0);

        // full-range span
        start_x = 16'd0;
        start_y = 16'd0;
        end_x   = 16'hFFFF;
        end_y   = 16'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cnt = 0;
        bad = 0;
        cyc = 0;
        while (cyc < 70000 && !(out_valid && out_last)) begin
            if (out_valid) begin
                if (out_x != cnt[15:0]) bad++;
                cnt++;
            end
            cyc++;
            @(negedge clk);
        end
        check("long_count", 64'(cnt + 1), 64'(65536));
        check("long_end", 64'({out_valid, out_last, out_x, out_y}),
              64'({2'b11, 16'hFFFF, 16'd1}));
        check("long_xstep", 64'(bad), 64'(0));
        @(negedge clk);
        check("long_done", 64'({out_valid, busy, done}), 64'(3'b001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
